// File: rtl/shift_exec_stage.sv
// Two-register shift execute stage: stage A holds the op, a barrel shifter feeds stage B.
// Optional zero/carry-out flags are built only when SHIFT_FLAGS_EN is defined.
module shift_exec_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_cnt,
  input  logic [1:0]  in_op,
  input  logic [2:0]  in_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_rd
`ifdef SHIFT_FLAGS_EN
  ,
  output logic        out_zero,
  output logic        out_cout
`endif
);

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  logic        a_valid;
  logic [15:0] a_data;
  logic [3:0]  a_cnt;
  logic [1:0]  a_op;
  logic [2:0]  a_rd;
  logic        b_valid;

  logic        accept;
  logic        advance_a;
  logic [15:0] shift_res;
  logic [31:0] rot_l;
  logic [31:0] rot_r;

  assign in_ready  = !a_valid || !b_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign advance_a = a_valid && (!b_valid || out_ready);
  assign out_valid = b_valid;

  // Rotations come from shifting a doubled copy of the operand.
  assign rot_l = {a_data, a_data} << a_cnt;
  assign rot_r = {a_data, a_data} >> a_cnt;

  always_comb begin
    shift_res = a_data;
    unique case (a_op)
      OP_ROL:  shift_res = rot_l[31:16];
      OP_SLL:  shift_res = a_data << a_cnt;
      OP_ROR:  shift_res = rot_r[15:0];
      OP_SRL:  shift_res = a_data >> a_cnt;
      default: shift_res = a_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
    end else if (flush) begin
      a_valid <= 1'b0;
    end else if (accept) begin
      a_valid <= 1'b1;
    end else if (advance_a) begin
      a_valid <= 1'b0;
    end
  end

  // Stage A payload is qualified by a_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_data <= in_data;
      a_cnt  <= in_cnt;
      a_op   <= in_op;
      a_rd   <= in_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid  <= 1'b0;
      out_data <= 16'h0000;
      out_rd   <= 3'd0;
    end else if (flush) begin
      b_valid <= 1'b0;
    end else if (advance_a) begin
      b_valid  <= 1'b1;
      out_data <= shift_res;
      out_rd   <= a_rd;
    end else if (out_ready) begin
      b_valid <= 1'b0;
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic       cout_nxt;
  logic [3:0] sll_idx;
  logic [3:0] srl_idx;

  // For cnt 1..15 the last bit out of SLL is data[16-cnt], of SRL data[cnt-1].
  assign sll_idx = 4'd0 - a_cnt;
  assign srl_idx = a_cnt - 4'd1;

  always_comb begin
    cout_nxt = 1'b0;
    if (a_cnt != 4'd0) begin
      unique case (a_op)
        OP_ROL:  cout_nxt = shift_res[0];
        OP_SLL:  cout_nxt = a_data[sll_idx];
        OP_ROR:  cout_nxt = shift_res[15];
        OP_SRL:  cout_nxt = a_data[srl_idx];
        default: cout_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero <= 1'b1;
      out_cout <= 1'b0;
    end else if (!flush && advance_a) begin
      out_zero <= (shift_res == 16'h0000);
      out_cout <= cout_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage; flag checks are compiled when SHIFT_FLAGS_EN is defined.
module tb_shift_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic [2:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_rd;
`ifdef SHIFT_FLAGS_EN
  logic        out_zero;
  logic        out_cout;
`endif

  int checks = 0;
  int errors = 0;

  shift_exec_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd)
`ifdef SHIFT_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_cout  (out_cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] cnt,
                       input logic [15:0] data, input logic [2:0] rd);
    in_valid = v;
    in_op    = op;
    in_cnt   = cnt;
    in_data  = data;
    in_rd    = rd;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    checks++;
    if (out_rd !== 3'd0) begin errors++; $display("FAIL reset_out_rd got %0d want 0", out_rd); end
`ifdef SHIFT_FLAGS_EN
    checks++;
    if (out_zero !== 1'b1 || out_cout !== 1'b0) begin
      errors++; $display("FAIL reset_flags got z%b c%b want z1 c0", out_zero, out_cout);
    end
`endif
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Single ops with hand-computed results: op, cnt, data, rd, result, zero, cout.
  task automatic test_shift_ops();
    logic [1:0]  t_op   [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
    logic [3:0]  t_cnt  [5] = '{4'd4, 4'd1, 4'd2, 4'd0, 4'd8};
    logic [15:0] t_data [5] = '{16'h00F1, 16'h0001, 16'h8003, 16'h1234, 16'h00FF};
    logic [2:0]  t_rd   [5] = '{3'd2, 3'd4, 3'd5, 3'd1, 3'd3};
    logic [15:0] t_res  [5] = '{16'h0F10, 16'h8000, 16'h2000, 16'h1234, 16'h0000};
    logic        t_zero [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        t_cout [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, t_op[i], t_cnt[i], t_data[i], t_rd[i]);
      tick();
      drive(1'b0, 2'b00, 4'd0, 16'hDEAD, 3'd0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL op%0d_early_valid got %b want 0", i, out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== t_res[i] || out_rd !== t_rd[i]) begin
        errors++;
        $display("FAIL op%0d_result got v%b %h rd%0d want v1 %h rd%0d", i, out_valid, out_data, out_rd, t_res[i], t_rd[i]);
      end
`ifdef SHIFT_FLAGS_EN
      checks++;
      if (out_zero !== t_zero[i] || out_cout !== t_cout[i]) begin
        errors++;
        $display("FAIL op%0d_flags got z%b c%b want z%b c%b", i, out_zero, out_cout, t_zero[i], t_cout[i]);
      end
`else
      if (t_zero[i] === 1'bx || t_cout[i] === 1'bx) $display("note: flag table entry %0d undefined", i);
`endif
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL op%0d_drain got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 4'd1, 16'h0003, 3'd1);
    tick();
    drive(1'b1, 2'b10, 4'd4, 16'h00F0, 3'd3);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_second got %b want 1", in_ready); end
    tick();
    drive(1'b1, 2'b00, 4'd1, 16'h8001, 3'd5);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0006 || out_rd !== 3'd1) begin
        errors++;
        $display("FAIL bp_hold%0d got rdy%b v%b %h rd%0d want rdy0 v1 0006 rd1", c, in_ready, out_valid, out_data, out_rd);
      end
      if (c < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    drive(1'b0, 2'b00, 4'd0, 16'h0000, 3'd0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h000F || out_rd !== 3'd3) begin
      errors++; $display("FAIL bp_drain1 got v%b %h rd%0d want v1 000f rd3", out_valid, out_data, out_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0003 || out_rd !== 3'd5) begin
      errors++; $display("FAIL bp_drain2 got v%b %h rd%0d want v1 0003 rd5", out_valid, out_data, out_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 4'd15, 16'hFFFF, 3'd6);
    tick();
    drive(1'b1, 2'b11, 4'd1, 16'h0001, 3'd7);
    tick();
    drive(1'b0, 2'b00, 4'd0, 16'h0000, 3'd0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_rd !== 3'd6) begin
      errors++; $display("FAIL b2b_first got v%b %h rd%0d want v1 8000 rd6", out_valid, out_data, out_rd);
    end
`ifdef SHIFT_FLAGS_EN
    checks++;
    if (out_zero !== 1'b0 || out_cout !== 1'b1) begin
      errors++; $display("FAIL b2b_first_flags got z%b c%b want z0 c1", out_zero, out_cout);
    end
`endif
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_rd !== 3'd7) begin
      errors++; $display("FAIL b2b_second got v%b %h rd%0d want v1 0000 rd7", out_valid, out_data, out_rd);
    end
`ifdef SHIFT_FLAGS_EN
    checks++;
    if (out_zero !== 1'b1 || out_cout !== 1'b1) begin
      errors++; $display("FAIL b2b_second_flags got z%b c%b want z1 c1", out_zero, out_cout);
    end
`endif
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 4'd1, 16'h0101, 3'd1);
    tick();
    drive(1'b1, 2'b01, 4'd2, 16'h0202, 3'd2);
    tick();
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 2'b01, 4'd3, 16'h0303, 3'd3);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 4'd0, 16'h0000, 3'd0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_next got v%b rdy%b want v0 rdy1", out_valid, in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_ghost got %0d results want 0", seen); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 4'd4, 16'h00F0, 3'd6);
    tick();
    drive(1'b0, 2'b00, 4'd0, 16'h0000, 3'd0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h000F) begin
      errors++; $display("FAIL rst_mid_pre got v%b %h want v1 000f", out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000) begin
      errors++; $display("FAIL rst_mid_async got v%b rdy%b %h want v0 rdy1 0000", out_valid, in_ready, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 4'd4, 16'h0F00, 3'd7);
    tick();
    drive(1'b0, 2'b00, 4'd0, 16'h0000, 3'd0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hF000 || out_rd !== 3'd7) begin
      errors++; $display("FAIL rst_mid_after got v%b %h rd%0d want v1 f000 rd7", out_valid, out_data, out_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_empty got %b want 0", out_valid); end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 4'd0, 16'h0000, 3'd0);
    test_reset();
    test_shift_ops();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  in  1  decode presents a shift op.
REQ-004 SHALL have ports: in_ready  out  1  stage accepts an op this cycle.
REQ-005 SHALL have ports: in_data  in  16  operand.
REQ-006 SHALL have ports: in_cnt  in  4  shift count, 0-15.
REQ-007 SHALL have ports: in_op  in  2  00 ROL, 01 SLL, 10 ROR, 11 SRL.
REQ-008 SHALL have ports: in_rd  in  3  destination register tag.
REQ-009 SHALL have ports: flush  in  1  squash all in-flight ops.
REQ-010 SHALL have ports: out_valid  out  1  result available to writeback.
REQ-011 SHALL have ports: out_ready  in  1  writeback accepts result.
REQ-012 SHALL have ports: out_data  out  16  shifted result.
REQ-013 SHALL have ports: out_rd  out  3  tag of out_data.
REQ-014 SHALL have ports, present only with SHIFT_FLAGS_EN: out_zero  out  1 (result==0); out_cout  out  1 (last bit shifted or rotated out).

Function
REQ-015 SHALL be a two-register pipeline: stage A latches {in_data,in_cnt,in_op,in_rd} on accept; a combinational barrel shifter from A drives stage B, which latches result and tag.
REQ-016 SHALL accept an op when in_valid && in_ready at a rising edge; transfer out when out_valid && out_ready.
REQ-017 SHALL give latency of exactly 2 cycles from accept edge to out_valid high with no backpressure; throughput 1 op/cycle.
REQ-018 SHALL drive in_ready = !A_valid || !B_valid || out_ready (combinational, no dependence on in_valid).
REQ-019 SHALL advance A into B whenever B is empty or B is being drained the same cycle; otherwise A holds.
REQ-020 SHALL hold out_data/out_rd stable while out_valid && !out_ready.
REQ-021 SHALL deliver results in strict acceptance order; no op is lost or duplicated under any backpressure pattern.
REQ-022 SHALL compute shift semantics: cnt=0 passes operand unchanged; SLL/SRL zero-fill; ROL/ROR rotate modulo 16.
REQ-023 SHALL clear A_valid and B_valid on the edge where flush=1; an op presented with in_valid the same cycle is dropped; in_ready stays per REQ-018.
REQ-024 SHALL ignore in_data/in_cnt/in_op/in_rd when not accepted; payload regs need no reset.

Reset
REQ-025 SHALL, while rst_n=0, force A_valid=0, B_valid=0, out_valid=0, in_ready=1, out_data=0, out_rd=0 (and out_zero=1, out_cout=0 when configured).
REQ-026 SHALL discard any in-flight ops on reset assertion mid-operation; first accept possible on first edge after rst_n rises.

Configuration
REQ-027 SHALL provide macro SHIFT_FLAGS_EN: defined -> out_zero and out_cout ports exist and are registered in stage B alongside out_data; undefined -> ports and logic absent, data path identical.
REQ-028 SHALL define out_cout as: cnt=0 -> 0; SLL -> in_data[16-cnt]; SRL -> in_data[cnt-1]; ROL -> result[0]; ROR -> result[15].

Verification
REQ-029 SHALL cover SLL 0x00F1 cnt 4, rd 2 -> out_data 0x0F10, out_rd 2, cout 0, zero 0, 2 cycles after accept.
REQ-030 SHALL cover ROR 0x0001 cnt 1 -> 0x8000, cout 1; SRL 0x8003 cnt 2 -> 0x2000, cout 1; ROL 0x1234 cnt 0 -> 0x1234, cout 0.
REQ-031 SHALL cover out_ready held 0 for 4 cycles with in_valid held 1 -> exactly 2 ops accepted, in_ready low next, then 3 results drain in order on release.
REQ-032 SHALL cover flush asserted with both stages full plus new in_valid -> out_valid 0 next cycle, none of the 3 ops ever appear.
REQ-033 SHALL cover rst_n pulsed low while out_valid=1 -> out_valid 0 immediately (async), in_ready 1, next accepted op emerges normally.
REQ-034 SHALL cover back-to-back SLL 0xFFFF cnt 15, then SRL 0x0001 cnt 1 -> 0x8000 then 0x0000 (zero 1, cout 1) on consecutive cycles.
